mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single 32-bit word RAM (1 read cycle returns both fetch and data words; a write cycle
//  performs no read) between instruction fetch and the load/store unit. Converts byte addresses
//  to word indices and adds byte/halfword stores via read-modify-write (RMW).
//  Sits between core fetch/MEM stages and the RAM instance.
// PARAMETERS
//  ADDR_W   12   RAM word-index width (depth 2**ADDR_W); byte address bits [ADDR_W+1:2] used
// PORTS
//  clk          in   1       rising-edge clock, shared with RAM
//  rst_n        in   1       asynchronous active-low reset
//  if_req       in   1       fetch request
//  if_addr      in   32      fetch byte address (bits [1:0] ignored)
//  if_ready     out  1       fetch accepted this cycle when if_req && if_ready
//  if_rvalid    out  1       instruction word valid (1 cycle after accept)
//  if_rdata     out  32      instruction word
//  dm_req       in   1       data request
//  dm_we        in   1       1 = store, 0 = load
//  dm_size      in   2       00 byte, 01 half, 10 word (11 treated as word)
//  dm_addr      in   32      data byte address
//  dm_wdata     in   32      store data, right-aligned
//  dm_ready     out  1       data request accepted when dm_req && dm_ready
//  dm_rvalid    out  1       load word valid (raw aligned word; extraction done by core)
//  dm_rdata     out  32      load word
//  dm_wdone     out  1       1-cycle pulse in the cycle the RAM write is performed
//  dm_misalign  out  1       1-cycle pulse: misaligned access accepted and dropped
//  ram_i_addr   out  32      RAM fetch word index (zero-extended ADDR_W bits)
//  ram_d_addr   out  32      RAM data word index
//  ram_d_in     out  32      RAM write word
//  ram_w_enable out  1       RAM write strobe
//  ram_i_data   in   32      RAM registered fetch word
//  ram_d_out    in   32      RAM registered data word
// BEHAVIOUR
//  - FSM states IDLE, RMW_WR. Request outputs (ready, ram_*) combinational from state + requests.
//  - IDLE: dm_ready=1. Load accepted: read cycle; dm_rvalid=1 next cycle, dm_rdata=ram_d_out.
//    Fetch in IDLE: if_ready=1 unless the same cycle carries an accepted store; read issued,
//    if_rvalid=1 next cycle, if_rdata=ram_i_data. Load + fetch same cycle: both served, 1 RAM read.
//  - Word store (aligned): ram_w_enable=1 that cycle, dm_wdone=1 that cycle, if_ready=0.
//  - Byte/half store: accept cycle issues RAM read of target word (fetch may NOT piggyback,
//    if_ready=0); next state RMW_WR: merge dm_wdata lanes (captured at accept) into ram_d_out,
//    write, dm_wdone=1, dm_ready=0, if_ready=0; return to IDLE. Throughput: 2 cycles per RMW.
//  - Back-to-back reads: one per cycle; rvalid/rdata pipelined, no bubbles.
//  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): accepted, no RAM access,
//    dm_misalign pulses in accept cycle; loads give no dm_rvalid.
//  - Addresses beyond 2**ADDR_W words wrap (upper bits dropped).
//  - ram_w_enable=1 only for aligned word store in IDLE or in RMW_WR; never with a read.
//  - Reset (async, any time): state=IDLE, if_rvalid=dm_rvalid=0, captured data cleared;
//    ram_w_enable drops immediately, in-flight RMW aborted with no write.
//  - Reset values: if_ready=dm_ready=0 while rst_n=0, all pulses 0, ram_* addresses 0.
// STRUCTURE
//  - Package mem_arb_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state typedef.
//  - Sub-module store_merge (combinational): old word, wdata, size, addr[1:0] -> merged word.
// TESTING
//  1. Reset, fetch 0x0,0x4,0x8 back-to-back -> if_rvalid 3 consecutive cycles, words RAM[0..2].
//  2. Word store 0xDEADBEEF @0x10 with fetch pending -> if_ready=0 that cycle; reload reads 0xDEADBEEF.
//  3. RAM[4]=0x11223344, byte store 0xAA @0x12 -> 2 cycles busy, dm_wdone 2nd cycle, RAM[4]=0x11AA3344.
//  4. Load @0x20 + fetch @0x40 same cycle -> both rvalid next cycle with correct words.
//  5. Half store @0x13 -> dm_misalign=1, no ram_w_enable, RAM unchanged.
//  6. rst_n low during RMW_WR -> no write, RAM unchanged, both rvalid=0, state IDLE after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/load-store RAM arbiter.
// Size encodings, FSM states and the misalignment rule.
package mem_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } arb_state_e;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      size == SZ_BYTE: m = 1'b0;
      size == SZ_HALF: m = off[0];
      default:         m = (off != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_arbiter_store_merge.sv
// Lane merge for partial stores: drops right-aligned store
// data into the addressed byte/half lanes of the old word.
module store_merge
  import mem_arb_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    unique case (1'b1)
      size == SZ_BYTE:
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      size == SZ_HALF:
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default:
        merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one word RAM between fetch and load/store,
// adding byte/half stores through a two-cycle RMW.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_wdone,
  output logic        dm_misalign,
  output logic [31:0] ram_i_addr,
  output logic [31:0] ram_d_addr,
  output logic [31:0] ram_d_in,
  output logic        ram_w_enable,
  input  logic [31:0] ram_i_data,
  input  logic [31:0] ram_d_out
);

  localparam int PADW = 32 - ADDR_W;

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;

  logic [ADDR_W-1:0] i_idx, d_idx;
  logic [31:0]       merged;
  logic              mis, is_store;
  logic              unused_addr;

  assign i_idx = if_addr[ADDR_W+1:2];
  assign d_idx = dm_addr[ADDR_W+1:2];
  assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                         dm_addr[31:ADDR_W+2]};

  store_merge u_merge (
    .old_word (ram_d_out),
    .wdata    (wdata_q),
    .size     (size_q),
    .offset   (off_q),
    .merged   (merged)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    off_d        = off_q;
    if_rvalid_d  = 1'b0;
    dm_rvalid_d  = 1'b0;
    if_ready     = 1'b0;
    dm_ready     = 1'b0;
    dm_wdone     = 1'b0;
    dm_misalign  = 1'b0;
    ram_w_enable = 1'b0;
    ram_i_addr   = '0;
    ram_d_addr   = '0;
    ram_d_in     = '0;
    mis          = misaligned(dm_size, dm_addr[1:0]);
    is_store     = 1'b0;
    // Nothing is accepted or strobed while reset is held.
    if (rst_n) begin
      ram_i_addr = {{PADW{1'b0}}, i_idx};
      unique case (state_q)
        ST_IDLE: begin
          dm_ready    = 1'b1;
          is_store    = dm_req && dm_we;
          if_ready    = !is_store;
          if_rvalid_d = if_req && !is_store;
          ram_d_addr  = {{PADW{1'b0}}, d_idx};
          ram_d_in    = dm_wdata;
          if (dm_req && mis) begin
            dm_misalign = 1'b1;
          end else if (is_store && dm_size[1]) begin
            ram_w_enable = 1'b1;
            dm_wdone     = 1'b1;
          end else if (is_store) begin
            state_d = ST_RMW_WR;
            addr_d  = d_idx;
            wdata_d = dm_wdata;
            size_d  = dm_size;
            off_d   = dm_addr[1:0];
          end else if (dm_req) begin
            dm_rvalid_d = 1'b1;
          end
        end
        ST_RMW_WR: begin
          ram_d_addr   = {{PADW{1'b0}}, addr_q};
          ram_d_in     = merged;
          ram_w_enable = 1'b1;
          dm_wdone     = 1'b1;
          state_d      = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      off_q       <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      off_q       <= off_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = ram_i_data;
  assign dm_rdata  = ram_d_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, vector table, directed
// corner cases and a random run against a transaction model.
module tb_mem_arbiter;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        preload = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [1:0]  dm_size = '0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic        dm_ready, dm_rvalid, dm_wdone, dm_misalign;
  logic [31:0] dm_rdata;
  logic [31:0] ram_i_addr, ram_d_addr, ram_d_in;
  logic        ram_w_enable;
  logic [31:0] ram_i_data, ram_d_out;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ready(dm_ready),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_wdone(dm_wdone),
    .dm_misalign(dm_misalign),
    .ram_i_addr(ram_i_addr), .ram_d_addr(ram_d_addr),
    .ram_d_in(ram_d_in), .ram_w_enable(ram_w_enable),
    .ram_i_data(ram_i_data), .ram_d_out(ram_d_out)
  );

  function automatic logic [31:0] pat(input int i);
    return (32'h9E3779B9 * i) ^ 32'h0BADF00D;
  endfunction

  // RAM: a write cycle performs no read
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
    end else if (ram_w_enable) begin
      ram[ram_d_addr[AW-1:0]] <= ram_d_in;
    end else begin
      ram_i_data <= ram[ram_i_addr[AW-1:0]];
      ram_d_out  <= ram[ram_d_addr[AW-1:0]];
    end
  end

  // Transaction-level model
  logic [31:0] mm [DEPTH];
  bit          rmw_pend;
  int          rmw_idx;
  logic [31:0] rmw_word;
  bit          e_ifv, e_dmv;
  logic [31:0] e_ifd, e_dmd;
  logic        last_ifv, last_dmv;
  logic [31:0] last_ifd, last_dmd;
  int          nvec, nerr;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] mod_merge(input logic [31:0] w,
      input logic [31:0] wd, input logic [1:0] sz, input logic [1:0] a);
    logic [7:0] b [4];
    logic [31:0] r;
    for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
    if (sz == 2'd0) begin
      b[a] = wd[7:0];
    end else if (sz == 2'd1) begin
      b[a & 2'd2] = wd[7:0];
      b[(a & 2'd2) + 2'd1] = wd[15:8];
    end else begin
      for (int k = 0; k < 4; k++) b[k] = wd[8*k +: 8];
    end
    r = {b[3], b[2], b[1], b[0]};
    return r;
  endfunction

  function automatic bit mod_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return a[0];
    return a[1:0] != 2'd0;
  endfunction

  task automatic step(input bit ir, input logic [31:0] ia, input bit dr,
      input bit we, input logic [1:0] sz, input logic [31:0] da,
      input logic [31:0] wd, output logic [4:0] flags);
    logic [4:0] ef;
    bit mis, st, nifv, ndmv;
    int di, ii;
    logic [31:0] nifd, ndmd;
    if_req = ir; if_addr = ia;
    dm_req = dr; dm_we = we; dm_size = sz; dm_addr = da; dm_wdata = wd;
    @(negedge clk);
    last_ifv = if_rvalid; last_ifd = if_rdata;
    last_dmv = dm_rvalid; last_dmd = dm_rdata;
    chk("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
    if (e_ifv) chk("if_rdata", if_rdata, e_ifd);
    chk("dm_rvalid", 32'(dm_rvalid), 32'(e_dmv));
    if (e_dmv) chk("dm_rdata", dm_rdata, e_dmd);
    di = int'(da[AW+1:2]);
    ii = int'(ia[AW+1:2]);
    nifv = 0; ndmv = 0; nifd = '0; ndmd = '0;
    mis = mod_mis(sz, da);
    st = dr && we;
    if (rmw_pend) begin
      ef = 5'b00110;
      chk("rmw_addr", ram_d_addr, 32'(rmw_idx));
      chk("rmw_data", ram_d_in, rmw_word);
    end else begin
      ef = {!st, 1'b1, st && !mis && sz[1], st && !mis && sz[1], dr && mis};
      if (ir && !st) begin
        nifv = 1; nifd = mm[ii];
        chk("i_addr", ram_i_addr, 32'(ii));
      end
      if (dr && !we && !mis) begin
        ndmv = 1; ndmd = mm[di];
      end
      if (dr && !mis) chk("d_addr", ram_d_addr, 32'(di));
      if (ef[2]) chk("d_in", ram_d_in, wd);
    end
    flags = {if_ready, dm_ready, ram_w_enable, dm_wdone, dm_misalign};
    chk("flags", 32'(flags), 32'(ef));
    if (rmw_pend) begin
      mm[rmw_idx] = rmw_word;
      rmw_pend = 0;
    end else if (ef[2]) begin
      mm[di] = wd;
    end else if (st && !mis) begin
      rmw_pend = 1;
      rmw_idx  = di;
      rmw_word = mod_merge(mm[di], wd, sz, da[1:0]);
    end
    e_ifv = nifv; e_ifd = nifd; e_dmv = ndmv; e_dmd = ndmd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(output logic [4:0] f);
    step(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, f);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    if ($urandom_range(0, 3) == 0) a = a | ($urandom_range(1, 255) << 16);
    return a;
  endfunction

  typedef struct {
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    bit          we;
    logic [1:0]  sz;
    logic [31:0] da;
    logic [31:0] wd;
    logic [4:0]  exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [4:0] f;
    for (int i = 0; i < DEPTH; i++) mm[i] = pat(i);
    nvec = 0; nerr = 0;
    rmw_pend = 0; e_ifv = 0; e_dmv = 0;

    // flags = {if_ready, dm_ready, w_enable, wdone, misalign}
    tbl[0]  = '{1, 32'h0,  0, 0, 2'd0, 32'h0,  32'h0,        5'b11000};
    tbl[1]  = '{1, 32'h4,  1, 0, 2'd2, 32'h20, 32'h0,        5'b11000};
    tbl[2]  = '{1, 32'h8,  1, 1, 2'd2, 32'h10, 32'hDEADBEEF, 5'b01110};
    tbl[3]  = '{1, 32'hC,  1, 1, 2'd2, 32'h11, 32'h12345678, 5'b01001};
    tbl[4]  = '{1, 32'h10, 1, 0, 2'd1, 32'h13, 32'h0,        5'b11001};
    tbl[5]  = '{1, 32'h14, 1, 1, 2'd0, 32'h12, 32'h000000AA, 5'b01000};
    tbl[6]  = '{1, 32'h18, 1, 0, 2'd2, 32'h20, 32'h0,        5'b00110};
    tbl[7]  = '{0, 32'h0,  1, 1, 2'd1, 32'h22, 32'h0000CAFE, 5'b01000};
    tbl[8]  = '{1, 32'h1C, 0, 0, 2'd0, 32'h0,  32'h0,        5'b00110};
    tbl[9]  = '{1, 32'h20, 1, 1, 2'd3, 32'h30, 32'hA5A5A5A5, 5'b01110};
    tbl[10] = '{1, 32'h24, 1, 0, 2'd3, 32'h31, 32'h0,        5'b11001};
    tbl[11] = '{0, 32'h0,  0, 0, 2'd0, 32'h0,  32'h0,        5'b11000};

    // reset: requests present but nothing accepted, addresses 0
    if_req = 1; if_addr = 32'h44; dm_req = 1; dm_we = 1; dm_addr = 32'h88;
    #1;
    chk("rst_flags", 32'({if_ready, dm_ready, ram_w_enable, dm_wdone,
                          dm_misalign}), 32'h0);
    chk("rst_i_addr", ram_i_addr, 32'h0);
    chk("rst_d_addr", ram_d_addr, 32'h0);
    chk("rst_rvalid", 32'({if_rvalid, dm_rvalid}), 32'h0);
    if_req = 0; dm_req = 0; dm_we = 0;
    @(posedge clk);
    #1;
    preload = 0;
    rst_n = 1;

    // 1: back-to-back fetches
    step(1, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, f);
    step(1, 32'h4, 0, 0, 2'd0, 32'h0, 32'h0, f);
    chk("fetch0", last_ifd, pat(0));
    step(1, 32'h8, 0, 0, 2'd0, 32'h0, 32'h0, f);
    chk("fetch1", last_ifd, pat(1));
    idle(f);
    chk("fetch2", last_ifd, pat(2));
    chk("fetch2_v", 32'(last_ifv), 32'h1);

    // vector table
    foreach (tbl[i]) begin
      step(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].we, tbl[i].sz,
           tbl[i].da, tbl[i].wd, f);
      chk($sformatf("tbl%0d", i), 32'(f), 32'(tbl[i].exp));
    end
    idle(f);

    // 2: word store with fetch pending, then reload
    step(1, 32'h40, 1, 1, 2'd2, 32'h10, 32'hDEADBEEF, f);
    chk("st_if_ready", 32'(f[4]), 32'h0);
    step(0, 32'h0, 1, 0, 2'd2, 32'h10, 32'h0, f);
    idle(f);
    chk("reload", last_dmd, 32'hDEADBEEF);

    // 3: byte store into a known word
    step(0, 32'h0, 1, 1, 2'd2, 32'h10, 32'h11223344, f);
    step(1, 32'h0, 1, 1, 2'd0, 32'h12, 32'h000000AA, f);
    step(1, 32'h0, 1, 0, 2'd2, 32'h0, 32'h0, f);
    chk("rmw_wdone", 32'(f[1]), 32'h1);
    idle(f);
    chk("rmw_ram", ram[4], 32'h11AA3344);

    // 4: load and fetch in one cycle
    step(1, 32'h40, 1, 0, 2'd2, 32'h20, 32'h0, f);
    idle(f);
    chk("dual_ld", last_dmd, mm[8]);
    chk("dual_if", last_ifd, mm[16]);

    // 5: misaligned half store
    step(0, 32'h0, 1, 1, 2'd1, 32'h13, 32'hFFFF, f);
    chk("mis_pulse", 32'(f[0]), 32'h1);
    idle(f);
    chk("mis_ram", ram[4], 32'h11AA3344);

    // 6: reset during the RMW write cycle
    step(0, 32'h0, 1, 1, 2'd0, 32'h18, 32'h77, f);
    if_req = 0; dm_req = 0; dm_we = 0;
    rst_n = 0;
    #1;
    chk("abort_wen", 32'(ram_w_enable), 32'h0);
    chk("abort_rv", 32'({if_rvalid, dm_rvalid}), 32'h0);
    @(posedge clk);
    #1;
    chk("abort_ram", ram[6], mm[6]);
    rst_n = 1;
    rmw_pend = 0; e_ifv = 0; e_dmv = 0;
    idle(f);
    chk("abort_idle", 32'(f), 32'h18);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), rnd_addr(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), rnd_addr(), $urandom(), f);
    end
    idle(f);
    idle(f);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
